// File: rtl/doraemon_pkg.sv
// Shared definitions for the doraemon feeder slice.
// Holds the feeder FSM encoding, the 38-bit candidate record layout
// ({id, size, iq, eq, size_w, iq_w, eq_w}, id in the MSBs), session
// defaults and a record packing helper.
package doraemon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_DONE  = 3'd4
    } feeder_state_e;

    localparam int ID_W   = 5;
    localparam int BYTE_W = 8;
    localparam int WGT_W  = 3;
    localparam int REC_W  = 38;
    localparam int CNT_W  = 13;

    // Field offsets inside the record, LSB first.
    localparam int OFF_EQ_W   = 0;
    localparam int OFF_IQ_W   = 3;
    localparam int OFF_SIZE_W = 6;
    localparam int OFF_EQ     = 9;
    localparam int OFF_IQ     = 17;
    localparam int OFF_SIZE   = 25;
    localparam int OFF_ID     = 33;

    localparam int INIT_N_DEF = 5;
    localparam int TOTAL_DEF  = 6000;

    function automatic logic [REC_W-1:0] pack_rec(
        input logic [ID_W-1:0]   id,
        input logic [BYTE_W-1:0] size,
        input logic [BYTE_W-1:0] iq,
        input logic [BYTE_W-1:0] eq,
        input logic [WGT_W-1:0]  size_w,
        input logic [WGT_W-1:0]  iq_w,
        input logic [WGT_W-1:0]  eq_w
    );
        return {id, size, iq, eq, size_w, iq_w, eq_w};
    endfunction

endpackage

// File: rtl/feeder_sync_fifo.sv
// Single-clock FIFO buffering candidate records in front of the selector.
// Ports: clk1/rst_n clock and async active-low reset; push/wdata write
// side; pop/rdata read side (rdata is the current head, valid when !empty);
// full/empty status. Pointers carry one extra wrap bit so full and empty
// are told apart without a separate counter.
module feeder_sync_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 8
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int ASIZE = $clog2(DEPTH);
    localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

    logic [ASIZE:0]   wr_ptr_r;
    logic [ASIZE:0]   rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (wr_ptr_r[ASIZE] != rd_ptr_r[ASIZE]) &&
                   (wr_ptr_r[ASIZE-1:0] == rd_ptr_r[ASIZE-1:0]);
    assign empty = (wr_ptr_r == rd_ptr_r);

    // Requests are self-guarded so a caller cannot overrun or underrun.
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    assign rdata = mem_r[rd_ptr_r[ASIZE-1:0]];

    // Read and write pointer advance.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(ASIZE+1){1'b0}};
            rd_ptr_r <= {(ASIZE+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Record storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk1) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[ASIZE-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/doraemon_feeder.sv
// Feeder in front of the clk1 top-5 selector.
// Ports: clk1/rst_n clock and async active-low reset; s_valid/s_ready plus
// s_* record fields from the producer; ready from the selector; in_valid
// plus registered record fields toward the selector; issued_cnt counts
// records issued this session; done is high once the session is complete.
// Protocol: the first INIT_N records are issued as soon as they are
// buffered, later ones only while ready is high, and issuing stops for
// good after TOTAL records.
module doraemon_feeder
    import doraemon_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int TOTAL  = TOTAL_DEF,
    parameter int INIT_N = INIT_N_DEF
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ID_W-1:0]   s_id,
    input  logic [BYTE_W-1:0] s_size,
    input  logic [BYTE_W-1:0] s_iq,
    input  logic [BYTE_W-1:0] s_eq,
    input  logic [WGT_W-1:0]  s_size_w,
    input  logic [WGT_W-1:0]  s_iq_w,
    input  logic [WGT_W-1:0]  s_eq_w,
    input  logic              ready,
    output logic              in_valid,
    output logic [ID_W-1:0]   doraemon_id,
    output logic [BYTE_W-1:0] size,
    output logic [BYTE_W-1:0] iq_score,
    output logic [BYTE_W-1:0] eq_score,
    output logic [WGT_W-1:0]  size_weight,
    output logic [WGT_W-1:0]  iq_weight,
    output logic [WGT_W-1:0]  eq_weight,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic              done
);

    localparam logic [CNT_W-1:0] TOTAL_C  = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] INIT_C   = CNT_W'(INIT_N);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    feeder_state_e    state_r;
    feeder_state_e    state_nxt_s;
    logic             issue_s;
    logic             push_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             cnt_below_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [REC_W-1:0] rec_in_s;
    logic [REC_W-1:0] head_s;

    assign rec_in_s    = pack_rec(s_id, s_size, s_iq, s_eq, s_size_w, s_iq_w, s_eq_w);
    assign s_ready     = !fifo_full_s && (state_r != ST_DONE);
    assign push_s      = s_valid && s_ready;
    assign cnt_below_s = (issued_cnt < TOTAL_C);
    assign cnt_inc_s   = issued_cnt + CNT_ONE;

    feeder_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk1  (clk1),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (rec_in_s),
        .pop   (issue_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // State register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and issue decision.
    // IDLE issues too when the FIFO is non-empty so the first record reaches
    // the selector one edge after it is buffered; IDLE then falls into INIT.
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_INIT: begin
                if (!fifo_empty_s && cnt_below_s) begin
                    issue_s = 1'b1;
                    if (cnt_inc_s == TOTAL_C) begin
                        state_nxt_s = ST_DONE;
                    end else if (cnt_inc_s >= INIT_C) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_INIT;
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_WAIT: begin
                // The transition cycle itself never pops.
                if (ready) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_ISSUE: begin
                if (!ready) begin
                    state_nxt_s = ST_WAIT;
                end else if (!fifo_empty_s && cnt_below_s) begin
                    issue_s = 1'b1;
                    if (cnt_inc_s == TOTAL_C) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output registers and issue counter; fields are zeroed when nothing
    // is issued so the selector never sees stale data.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            in_valid    <= 1'b0;
            doraemon_id <= 5'd0;
            size        <= 8'd0;
            iq_score    <= 8'd0;
            eq_score    <= 8'd0;
            size_weight <= 3'd0;
            iq_weight   <= 3'd0;
            eq_weight   <= 3'd0;
            issued_cnt  <= 13'd0;
            done        <= 1'b0;
        end else begin
            done <= (state_nxt_s == ST_DONE);
            if (issue_s) begin
                in_valid    <= 1'b1;
                doraemon_id <= head_s[OFF_ID +: ID_W];
                size        <= head_s[OFF_SIZE +: BYTE_W];
                iq_score    <= head_s[OFF_IQ +: BYTE_W];
                eq_score    <= head_s[OFF_EQ +: BYTE_W];
                size_weight <= head_s[OFF_SIZE_W +: WGT_W];
                iq_weight   <= head_s[OFF_IQ_W +: WGT_W];
                eq_weight   <= head_s[OFF_EQ_W +: WGT_W];
                issued_cnt  <= cnt_inc_s;
            end else begin
                in_valid    <= 1'b0;
                doraemon_id <= 5'd0;
                size        <= 8'd0;
                iq_score    <= 8'd0;
                eq_score    <= 8'd0;
                size_weight <= 3'd0;
                iq_weight   <= 3'd0;
                eq_weight   <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_doraemon_feeder.sv
// Self-checking bench for doraemon_feeder: a main instance (TOTAL=6000)
// and a short-session instance (TOTAL=12). Accepted records are queued
// at the handshake and compared in order when in_valid is seen.
module tb_doraemon_feeder;
    import doraemon_pkg::*;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0, s_valid_e = 1'b0;
    logic        ready = 1'b0, ready_e = 1'b0;
    logic [4:0]  s_id = 5'd0;
    logic [7:0]  s_size = 8'd0, s_iq = 8'd0, s_eq = 8'd0;
    logic [2:0]  s_size_w = 3'd0, s_iq_w = 3'd0, s_eq_w = 3'd0;

    logic        s_ready, in_valid, done;
    logic [4:0]  doraemon_id;
    logic [7:0]  size, iq_score, eq_score;
    logic [2:0]  size_weight, iq_weight, eq_weight;
    logic [12:0] issued_cnt;

    logic        s_ready_e, in_valid_e, done_e;
    logic [4:0]  doraemon_id_e;
    logic [7:0]  size_e, iq_score_e, eq_score_e;
    logic [2:0]  size_weight_e, iq_weight_e, eq_weight_e;
    logic [12:0] issued_cnt_e;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int pulses_e = 0;
    int accepted = 0;
    logic [37:0] exp_q[$];
    logic [37:0] exp_q_e[$];
    logic [37:0] exp_rec, exp_rec_e;

    wire [37:0] in_rec    = {s_id, s_size, s_iq, s_eq, s_size_w, s_iq_w, s_eq_w};
    wire [37:0] out_rec   = {doraemon_id, size, iq_score, eq_score, size_weight, iq_weight, eq_weight};
    wire [37:0] out_rec_e = {doraemon_id_e, size_e, iq_score_e, eq_score_e,
                             size_weight_e, iq_weight_e, eq_weight_e};

    doraemon_feeder dut (
        .clk1(clk1), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_id(s_id), .s_size(s_size), .s_iq(s_iq), .s_eq(s_eq),
        .s_size_w(s_size_w), .s_iq_w(s_iq_w), .s_eq_w(s_eq_w), .ready(ready),
        .in_valid(in_valid), .doraemon_id(doraemon_id), .size(size),
        .iq_score(iq_score), .eq_score(eq_score), .size_weight(size_weight),
        .iq_weight(iq_weight), .eq_weight(eq_weight), .issued_cnt(issued_cnt),
        .done(done)
    );

    doraemon_feeder #(.TOTAL(12)) dut_e (
        .clk1(clk1), .rst_n(rst_n), .s_valid(s_valid_e), .s_ready(s_ready_e),
        .s_id(s_id), .s_size(s_size), .s_iq(s_iq), .s_eq(s_eq),
        .s_size_w(s_size_w), .s_iq_w(s_iq_w), .s_eq_w(s_eq_w), .ready(ready_e),
        .in_valid(in_valid_e), .doraemon_id(doraemon_id_e), .size(size_e),
        .iq_score(iq_score_e), .eq_score(eq_score_e), .size_weight(size_weight_e),
        .iq_weight(iq_weight_e), .eq_weight(eq_weight_e), .issued_cnt(issued_cnt_e),
        .done(done_e)
    );

    always #5 clk1 = ~clk1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record content is a fixed function of the id: id 6 gives size A5, size_w 7.
    function automatic logic [37:0] rec_of(input logic [4:0] id);
        logic [7:0] id8;
        id8 = {3'b000, id};
        return {id, id8 ^ 8'hA3, id8 * 8'd3, ~id8, id[2:0] + 3'd1, id[2:0], ~id[2:0]};
    endfunction

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic push_rec(input bit to_e, input logic [4:0] id, input bit must);
        bit acc;
        int budget;
        {s_id, s_size, s_iq, s_eq, s_size_w, s_iq_w, s_eq_w} = rec_of(id);
        if (to_e) s_valid_e = 1'b1;
        else      s_valid   = 1'b1;
        acc = 1'b0;
        budget = 0;
        while (!acc && budget < 60) begin
            acc = to_e ? s_ready_e : s_ready;
            tick();
            budget++;
        end
        s_valid   = 1'b0;
        s_valid_e = 1'b0;
        if (acc) accepted++;
        else if (must) check_eq("push_timeout", acc, 1);
    endtask

    // Scoreboard, main instance: compare issues in order, push accepts.
    always @(negedge clk1) begin
        if (rst_n) begin
            if (in_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    check_eq("issue_with_empty_sb", exp_q.size(), 1);
                end else begin
                    exp_rec = exp_q.pop_front();
                    check_eq("issued_rec", out_rec, exp_rec);
                end
            end else begin
                check_eq("idle_fields_zero", out_rec, 38'd0);
            end
            if (s_valid && s_ready) exp_q.push_back(in_rec);
        end
    end

    // Scoreboard, short-session instance.
    always @(negedge clk1) begin
        if (rst_n) begin
            if (in_valid_e) begin
                pulses_e++;
                if (exp_q_e.size() == 0) begin
                    check_eq("e_issue_with_empty_sb", exp_q_e.size(), 1);
                end else begin
                    exp_rec_e = exp_q_e.pop_front();
                    check_eq("e_issued_rec", out_rec_e, exp_rec_e);
                end
            end
            if (s_valid_e && s_ready_e) exp_q_e.push_back(in_rec);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, p0, t;
        repeat (3) @(posedge clk1);
        #3 rst_n = 1'b1;

        // Reset state
        check_eq("rst_in_valid", in_valid, 0);
        check_eq("rst_fields", out_rec, 0);
        check_eq("rst_issued_cnt", issued_cnt, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_s_ready", s_ready, 1);

        // Session end on the TOTAL=12 instance, ready held high
        ready_e = 1'b1;
        for (int id = 1; id <= 15; id++) push_rec(1'b1, 5'(id), id <= 12);
        repeat (3) tick();
        check_eq("end_pulses", pulses_e, 12);
        check_eq("end_done", done_e, 1);
        check_eq("end_s_ready", s_ready_e, 0);
        check_eq("end_cnt", issued_cnt_e, 12);
        repeat (5) tick();
        check_eq("end_cnt_hold", issued_cnt_e, 12);
        check_eq("end_iv_low", in_valid_e, 0);
        check_eq("main_untouched", issued_cnt, 0);

        // Init load: ids 1..5 back to back with ready low
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            {s_id, s_size, s_iq, s_eq, s_size_w, s_iq_w, s_eq_w} = rec_of(5'(i));
            s_valid = 1'b1;
            check_eq("init_s_ready", s_ready, 1);
            tick();
            check_eq("init_iv_timing", in_valid, (i >= 2));
        end
        s_valid = 1'b0;
        tick();
        check_eq("init_last_iv", in_valid, 1);
        check_eq("init_last_id", doraemon_id, 5);
        check_eq("init_cnt", issued_cnt, 5);
        tick();
        check_eq("init_wait_iv", in_valid, 0);

        // Ready gating
        for (int id = 6; id <= 8; id++) push_rec(1'b0, 5'(id), 1'b1);
        repeat (7) begin
            tick();
            check_eq("gate_iv_low", in_valid, 0);
        end
        ready = 1'b1;
        tick();
        check_eq("gate_transition_iv", in_valid, 0);
        tick();
        check_eq("gate_iv6", in_valid, 1);
        check_eq("gate_id6", doraemon_id, 6);
        check_eq("gate_size6", size, 8'hA5);
        check_eq("gate_sizew6", size_weight, 3'd7);
        tick();
        check_eq("gate_id7", doraemon_id, 7);
        tick();
        check_eq("gate_id8", doraemon_id, 8);
        tick();
        check_eq("gate_empty_iv", in_valid, 0);
        check_eq("gate_cnt", issued_cnt, 8);
        ready = 1'b0;
        tick();

        // Backpressure: DEPTH+2 records with ready low
        acc0 = accepted;
        fork
            begin
                for (int k = 0; k < 10; k++) push_rec(1'b0, 5'(9 + k), 1'b1);
            end
            begin
                int tw;
                tw = 0;
                while ((accepted - acc0) < 8 && tw < 100) begin
                    tick();
                    tw++;
                end
                check_eq("bp_accepted8", accepted - acc0, 8);
                check_eq("bp_s_ready_low", s_ready, 0);
                repeat (5) begin
                    tick();
                    check_eq("bp_hold_s_ready", s_ready, 0);
                    check_eq("bp_hold_iv", in_valid, 0);
                end
                check_eq("bp_ninth_held", accepted - acc0, 8);
                ready = 1'b1;
            end
        join
        t = 0;
        while (exp_q.size() > 0 && t < 100) begin
            tick();
            t++;
        end
        tick();
        check_eq("bp_drained", exp_q.size(), 0);
        check_eq("bp_cnt", issued_cnt, 18);

        // Ready drop mid-burst
        ready = 1'b0;
        tick();
        for (int id = 19; id <= 24; id++) push_rec(1'b0, 5'(id), 1'b1);
        p0 = pulses;
        ready = 1'b1;
        tick();
        check_eq("drop_transition_iv", in_valid, 0);
        for (int id = 19; id <= 21; id++) begin
            tick();
            check_eq("drop_burst_iv", in_valid, 1);
            check_eq("drop_burst_id", doraemon_id, id);
        end
        ready = 1'b0;
        tick();
        check_eq("drop_iv_low", in_valid, 0);
        check_eq("drop_three_pulses", pulses - p0, 3);
        repeat (4) begin
            tick();
            check_eq("drop_hold_iv", in_valid, 0);
        end
        check_eq("drop_cnt", issued_cnt, 21);
        ready = 1'b1;
        tick();
        check_eq("drop_resume_gap", in_valid, 0);
        tick();
        check_eq("drop_resume_id", doraemon_id, 22);
        t = 0;
        while (exp_q.size() > 0 && t < 100) begin
            tick();
            t++;
        end
        tick();
        check_eq("drop_drained", exp_q.size(), 0);
        check_eq("drop_cnt_final", issued_cnt, 24);

        // Async reset mid-ISSUE
        push_rec(1'b0, 5'd25, 1'b1);
        push_rec(1'b0, 5'd26, 1'b1);
        check_eq("pre_reset_iv", in_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_iv", in_valid, 0);
        check_eq("arst_fields", out_rec, 0);
        check_eq("arst_cnt", issued_cnt, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_done_e", done_e, 0);
        exp_q.delete();
        exp_q_e.delete();
        ready = 1'b0;
        #10 rst_n = 1'b1;
        repeat (3) begin
            tick();
            check_eq("post_rst_fifo_empty", in_valid, 0);
        end
        check_eq("post_rst_s_ready", s_ready, 1);
        p0 = pulses;
        for (int id = 1; id <= 5; id++) push_rec(1'b0, 5'(id), 1'b1);
        repeat (2) tick();
        check_eq("reinit_pulses", pulses - p0, 5);
        check_eq("reinit_cnt", issued_cnt, 5);
        check_eq("reinit_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
